// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings for the multicycle MIPS controller (MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds HALT)
package multicycle_ctrl_pkg;
  localparam int OP_W = 6;
  localparam int ST_W = 4;
  typedef enum logic [ST_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_e;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALUCONT_AND = 3'b000;
  localparam logic [2:0] ALUCONT_OR  = 3'b001;
  localparam logic [2:0] ALUCONT_ADD = 3'b010;
  localparam logic [2:0] ALUCONT_SUB = 3'b110;
  localparam logic [2:0] ALUCONT_SLT = 3'b111;
  localparam logic [2:0] ALUSRCB_B    = 3'b000;
  localparam logic [2:0] ALUSRCB_FOUR = 3'b001;
  localparam logic [2:0] ALUSRCB_SHT  = 3'b011;
  localparam logic [2:0] ALUSRCB_IMM  = 3'b100;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [2:0] alusrcb;
    logic       irwrite;
  } ctrl_t;
  function automatic logic funct_known(input logic [OP_W-1:0] f);
    return f == FN_ADD || f == FN_SUB || f == FN_AND || f == FN_OR || f == FN_SLT;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ctrl_aludec: maps aluop and R-type funct to the ALU control code
module ctrl_aludec
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0]      aluop_i,
  input  logic [OP_W-1:0] funct_i,
  output logic [2:0]      alucont_o
);
  logic [2:0] fn_code;
  // funct decode; unknown functs fall back to ADD
  always_comb begin
    fn_code = funct_i == FN_SUB ? ALUCONT_SUB :
              funct_i == FN_AND ? ALUCONT_AND :
              funct_i == FN_OR  ? ALUCONT_OR  :
              funct_i == FN_SLT ? ALUCONT_SLT : ALUCONT_ADD;
    alucont_o = aluop_i == ALUOP_SUB   ? ALUCONT_SUB :
                aluop_i == ALUOP_FUNCT ? fn_code : ALUCONT_ADD;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the multicycle MIPS datapath (MULTICYCLE_CTRL_ILLEGAL_TRAP_EN enables the HALT trap)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op_i,
  input  logic [OP_W-1:0] funct_i,
  input  logic            zero_i,
  input  logic            memready_i,
  output logic            memread_o,
  output logic            memwrite_o,
  output logic            alusrca_o,
  output logic            memtoreg_o,
  output logic            iord_o,
  output logic            pcen_o,
  output logic            regwrite_o,
  output logic            regdst_o,
  output logic [1:0]      pcsource_o,
  output logic [2:0]      alusrcb_o,
  output logic            irwrite_o,
  output logic [2:0]      alucont_o,
  output logic            illegal_o
);
  state_e     state_q, state_d;
  ctrl_t      ctrl, ctrl_o;
  logic [1:0] aluop;
  logic       alu_en;
  logic       illegal_c;
  logic [2:0] alucont;
  ctrl_aludec u_aludec (.aluop_i(aluop), .funct_i(funct_i), .alucont_o(alucont));
  // state register; active-low synchronous reset returns to FETCH
  always_ff @(posedge clk) state_q <= !rst ? S_FETCH : state_d;
  // next state and per-state control decode
  always_comb begin
    state_d   = S_FETCH;
    ctrl      = '0;
    aluop     = ALUOP_ADD;
    alu_en    = 1'b1;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = ALUSRCB_FOUR;
        ctrl.irwrite = memready_i;
        ctrl.pcen    = memready_i;
        state_d      = memready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctrl.alusrcb = ALUSRCB_SHT;
        state_d = (op_i == OP_LW || op_i == OP_SW) ? S_MEMADR :
                  op_i == OP_RTYPE ? S_RTYPEEX :
                  op_i == OP_BEQ   ? S_BEQEX :
                  op_i == OP_ADDI  ? S_ADDIEX :
                  op_i == OP_J     ? S_JEX :
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                  S_HALT;
`else
                  S_FETCH;
`endif
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        state_d      = op_i == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        state_d      = memready_i ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = memready_i ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        aluop        = ALUOP_FUNCT;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        state_d      = funct_known(funct_i) ? S_RTYPEWB : S_HALT;
`else
        state_d      = S_RTYPEWB;
`endif
      end
      S_RTYPEWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.alusrcb  = ALUSRCB_B;
        ctrl.pcsource = PCSRC_ALUOUT;
        ctrl.pcen     = zero_i;
        aluop         = ALUOP_SUB;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_JEX: begin
        ctrl.pcsource = PCSRC_JUMP;
        ctrl.pcen     = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        alu_en    = 1'b0;
        illegal_c = 1'b1;
        state_d   = S_HALT;
      end
`endif
      default: alu_en = 1'b0;
    endcase
  end
  // reset blanks every output so nothing is written while rst is low
  assign ctrl_o     = rst ? ctrl : '0;
  assign memread_o  = ctrl_o.memread;
  assign memwrite_o = ctrl_o.memwrite;
  assign alusrca_o  = ctrl_o.alusrca;
  assign memtoreg_o = ctrl_o.memtoreg;
  assign iord_o     = ctrl_o.iord;
  assign pcen_o     = ctrl_o.pcen;
  assign regwrite_o = ctrl_o.regwrite;
  assign regdst_o   = ctrl_o.regdst;
  assign pcsource_o = ctrl_o.pcsource;
  assign alusrcb_o  = ctrl_o.alusrcb;
  assign irwrite_o  = ctrl_o.irwrite;
  assign alucont_o  = (rst && alu_en) ? alucont : 3'b000;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal_o  = rst & illegal_c;
`else
  assign illegal_o  = 1'b0 & illegal_c;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction-level checks of multicycle_ctrl against a step-table model
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] op_i = '0, funct_i = '0;
  logic zero_i = 1'b0, memready_i = 1'b0;
  logic memread_o, memwrite_o, alusrca_o, memtoreg_o, iord_o, pcen_o, regwrite_o, regdst_o;
  logic [1:0] pcsource_o;
  logic [2:0] alusrcb_o, alucont_o;
  logic irwrite_o, illegal_o;
  int checks = 0, errors = 0;
  int pcen_cnt, mw_cnt, rw_cnt, iord_cnt;
  localparam int S_Z = 0, S_F = 1, S_D = 2, S_MA = 3, S_MR = 4, S_MWB = 5, S_MW = 6,
                 S_RX = 7, S_RWB = 8, S_BX = 9, S_AX = 10, S_AWB = 11, S_JX = 12, S_H = 13;
  logic [5:0] known_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  logic [5:0] known_op [6] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i), .memready_i(memready_i),
    .memread_o(memread_o), .memwrite_o(memwrite_o), .alusrca_o(alusrca_o), .memtoreg_o(memtoreg_o),
    .iord_o(iord_o), .pcen_o(pcen_o), .regwrite_o(regwrite_o), .regdst_o(regdst_o),
    .pcsource_o(pcsource_o), .alusrcb_o(alusrcb_o), .irwrite_o(irwrite_o), .alucont_o(alucont_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] exp_out(input int s, input logic rdy, input logic z, input logic [5:0] fn);
    logic mr = 0, mw = 0, asa = 0, m2r = 0, io = 0, pe = 0, rw = 0, rd = 0, irw = 0, ill = 0;
    logic [1:0] ps = 0;
    logic [2:0] asb = 0, ac = 3'b010;
    case (s)
      S_F:   begin mr = 1; asb = 3'b001; irw = rdy; pe = rdy; end
      S_D:   asb = 3'b011;
      S_MA:  begin asa = 1; asb = 3'b100; end
      S_MR:  begin mr = 1; io = 1; end
      S_MWB: begin rw = 1; m2r = 1; end
      S_MW:  begin mw = 1; io = 1; end
      S_RX:  begin
        asa = 1;
        ac = fn == 6'h22 ? 3'b110 : fn == 6'h24 ? 3'b000 : fn == 6'h25 ? 3'b001 :
             fn == 6'h2a ? 3'b111 : 3'b010;
      end
      S_RWB: begin rw = 1; rd = 1; end
      S_BX:  begin asa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      S_AX:  begin asa = 1; asb = 3'b100; end
      S_AWB: rw = 1;
      S_JX:  begin ps = 2'b10; pe = 1; end
      S_H:   begin ac = 0; ill = 1; end
      default: ac = 0;
    endcase
    return {mr, mw, asa, m2r, io, pe, rw, rd, ps, asb, irw, ac, ill};
  endfunction

  task automatic cyc(input int s, input logic r, input logic rdy, input logic z,
                     input logic [5:0] op, input logic [5:0] fn, input string nm);
    logic [17:0] obs, exp;
    @(negedge clk);
    rst = r; memready_i = rdy; zero_i = z; op_i = op; funct_i = fn;
    #1;
    obs = {memread_o, memwrite_o, alusrca_o, memtoreg_o, iord_o, pcen_o, regwrite_o, regdst_o,
           pcsource_o, alusrcb_o, irwrite_o, alucont_o, illegal_o};
    exp = exp_out(s, rdy, z, fn);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s step=%0d op=%h fn=%h got=%h want=%h", nm, s, op, fn, obs, exp);
    end
    pcen_cnt += int'(pcen_o); mw_cnt += int'(memwrite_o);
    rw_cnt += int'(regwrite_o); iord_cnt += int'(iord_o);
  endtask

  // instruction-level model: which steps an opcode walks through
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wait_n,
                           input int zsel, input string nm);
    int q[$];
    int n;
    logic z;
    q = '{S_F, S_D};
    case (op)
      6'h23: q = {q, S_MA, S_MR, S_MWB};
      6'h2b: q = {q, S_MA, S_MW};
      6'h00: q = {q, S_RX, S_RWB};
      6'h04: q = {q, S_BX};
      6'h08: q = {q, S_AX, S_AWB};
      6'h02: q = {q, S_JX};
      default: ;
    endcase
    pcen_cnt = 0; mw_cnt = 0; rw_cnt = 0; iord_cnt = 0;
    foreach (q[i]) begin
      z = zsel < 0 ? 1'($urandom) : 1'(zsel);
      if (q[i] == S_F || q[i] == S_MR || q[i] == S_MW) begin
        n = wait_n < 0 ? $urandom_range(0, 2) : (q[i] == S_F ? 0 : wait_n);
        repeat (n) cyc(q[i], 1, 0, z, op, fn, nm);
        cyc(q[i], 1, 1, z, op, fn, nm);
      end else cyc(q[i], 1, 1'($urandom), z, op, fn, nm);
    end
  endtask

  task automatic test_reset();
    cyc(S_Z, 0, 1, 1, 6'h23, 6'h20, "reset_blank");
    cyc(S_Z, 0, 1, 1, 6'h00, 6'h2a, "reset_blank2");
    cyc(S_F, 1, 0, 0, 6'h00, 6'h00, "reset_fetch");
  endtask

  task automatic test_lw();
    run_instr(6'h23, 6'h00, 0, 0, "lw");
    checks++;
    if (pcen_cnt !== 1) begin errors++; $display("FAIL lw_pcen_count got=%0d want=1", pcen_cnt); end
  endtask

  task automatic test_sw_stall();
    run_instr(6'h2b, 6'h00, 3, 0, "sw");
    checks++;
    if (mw_cnt !== 4 || iord_cnt !== 4) begin
      errors++; $display("FAIL sw_stall memwrite=%0d iord=%0d want=4/4", mw_cnt, iord_cnt);
    end
    checks++;
    if (rw_cnt !== 0) begin errors++; $display("FAIL sw_regwrite got=%0d want=0", rw_cnt); end
  endtask

  task automatic test_beq();
    run_instr(6'h04, 6'h00, 0, 1, "beq_taken");
    run_instr(6'h04, 6'h00, 0, 0, "beq_not_taken");
    checks++;
    if (pcen_cnt !== 1) begin errors++; $display("FAIL beq_nt_pcen got=%0d want=1", pcen_cnt); end
  endtask

  task automatic test_rtype_j();
    foreach (known_fn[i]) run_instr(6'h00, known_fn[i], 0, 0, "rtype");
    run_instr(6'h02, 6'h00, 0, 0, "jump");
    run_instr(6'h08, 6'h00, 0, 0, "addi");
  endtask

  task automatic test_long_stall();
    run_instr(6'h23, 6'h00, 20, 0, "lw_long_stall");
  endtask

  task automatic test_reset_mid();
    cyc(S_F, 1, 1, 0, 6'h23, 6'h00, "mid_f");
    cyc(S_D, 1, 1, 0, 6'h23, 6'h00, "mid_d");
    cyc(S_MA, 1, 1, 0, 6'h23, 6'h00, "mid_ma");
    cyc(S_MR, 1, 1, 0, 6'h23, 6'h00, "mid_mr");
    cyc(S_Z, 0, 1, 0, 6'h23, 6'h00, "mid_reset_wb");
    cyc(S_F, 1, 0, 0, 6'h23, 6'h00, "mid_after_reset");
  endtask

  task automatic test_illegal();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    cyc(S_F, 1, 1, 0, 6'h3f, 6'h00, "ill_f");
    cyc(S_D, 1, 1, 0, 6'h3f, 6'h00, "ill_d");
    repeat (5) cyc(S_H, 1, 1'($urandom), 1, 6'h23, 6'h20, "ill_halt");
    cyc(S_Z, 0, 1, 0, 6'h00, 6'h00, "ill_reset");
    cyc(S_F, 1, 0, 0, 6'h00, 6'h00, "ill_fetch");
`else
    run_instr(6'h3f, 6'h00, 0, 0, "illegal_nop");
    checks++;
    if (rw_cnt !== 0 || mw_cnt !== 0) begin
      errors++; $display("FAIL illegal_nop_writes rw=%0d mw=%0d want=0/0", rw_cnt, mw_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    repeat (60) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      op = known_op[$urandom_range(0, 5)];
      fn = known_fn[$urandom_range(0, 4)];
`else
      op = $urandom_range(0, 3) == 0 ? 6'($urandom) : known_op[$urandom_range(0, 5)];
      fn = $urandom_range(0, 2) == 0 ? 6'($urandom) : known_fn[$urandom_range(0, 4)];
`endif
      run_instr(op, fn, -1, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_rtype_j();
    test_long_stall();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the multicycle MIPS datapath.
- Every cycle it drives all datapath select/enable lines from the current state and the fetched instruction's op and funct fields.
- It also drives memory read/write strobes and stalls on a memory-ready handshake.
- Sits beside the datapath in the CPU top. Consumes the datapath's instruction and zero flag; produces the datapath's control inputs.

Parameters:
- OP_W, 6, opcode/funct field width
- ST_W, 4, state register width

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- op_i  input  6  instruction[31:26] from instruction register
- funct_i  input  6  instruction[5:0]
- zero_i  input  1  ALU result==0 from datapath
- memready_i  input  1  memory completes current access this cycle
- memread_o  output  1  memory read strobe
- memwrite_o  output  1  memory write strobe
- alusrca_o  output  1  0=PC, 1=A register
- memtoreg_o  output  1  0=ALUOut, 1=MDR
- iord_o  output  1  0=PC address, 1=ALUOut address
- pcen_o  output  1  PC load enable
- regwrite_o  output  1  register file write
- regdst_o  output  1  0=rt, 1=rd
- pcsource_o  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 zero
- alusrcb_o  output  3  000 B, 001 four, 011 shifted target, 100 sign-extended immediate
- irwrite_o  output  1  instruction register load
- alucont_o  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- illegal_o  output  1  unknown opcode seen (feature only; tied 0 otherwise)

Behaviour:
- State updates on the rising clk edge.
- When rst==0 at an edge, state<=FETCH and illegal flag clears.
- While rst==0, every output is forced to 0 combinationally. This forbids any PC, IR, register or memory write during reset.
- Outputs are decoded from state only, except:
  - pcen_o, irwrite_o and the state advance in memory states are gated by memready_i.
  - pcen_o in BEQEX depends on zero_i.
- Unlisted outputs are 0 in each state; alucont_o defaults to ADD.

State transitions and per-state outputs:
- FETCH:
  - Outputs: memread, iord=0, alusrca=0, alusrcb=001, pcsource=00.
  - irwrite=memready_i, pcen=memready_i.
  - Holds in FETCH while memready_i==0; on ready -> DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=011, ADD. The branch target is captured in ALUOut.
  - Next state by op:
    - 100011 LW or 101011 SW -> MEMADR
    - 000000 R-type -> RTYPEEX
    - 000100 BEQ -> BEQEX
    - 001000 ADDI -> ADDIEX
    - 000010 J -> JEX
    - other -> FETCH (treated as NOP)
- MEMADR:
  - Outputs: alusrca=1, alusrcb=100, ADD.
  - LW -> MEMRD; SW -> MEMWR.
- MEMRD:
  - Outputs: memread, iord=1.
  - Waits for memready_i, then -> MEMWB.
- MEMWB:
  - Outputs: regwrite, regdst=0, memtoreg=1.
  - -> FETCH.
- MEMWR:
  - Outputs: memwrite, iord=1.
  - Waits for memready_i, then -> FETCH. memwrite_o stays high throughout the wait.
- RTYPEEX:
  - Outputs: alusrca=1, alusrcb=000, alucont from funct:
    - 100000 -> ADD
    - 100010 -> SUB
    - 100100 -> AND
    - 100101 -> OR
    - 101010 -> SLT
    - other -> ADD
  - -> RTYPEWB.
- RTYPEWB:
  - Outputs: regwrite, regdst=1, memtoreg=0.
  - -> FETCH.
- BEQEX:
  - Outputs: alusrca=1, alusrcb=000, SUB, pcsource=01, pcen=zero_i.
  - -> FETCH.
- ADDIEX:
  - Outputs: alusrca=1, alusrcb=100, ADD.
  - -> ADDIWB.
- ADDIWB:
  - Outputs: regwrite, regdst=0, memtoreg=0.
  - -> FETCH.
- JEX:
  - Outputs: pcsource=10, pcen=1.
  - -> FETCH.

Latency in cycles, with zero memory wait:
- LW 5; SW 4; R-type 4; ADDI 4; BEQ 3; J 3.
- Each memory wait cycle adds one cycle.

Boundary conditions:
- Reset asserted mid-instruction: the next state is FETCH regardless of the current state. No partial register or memory write completes after the reset edge.
- memready_i held low indefinitely: FSM stalls with strobes held. No timeout.
- Unreachable encodings of the ST_W-bit state -> FETCH with all outputs 0.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE -> HALT state.
  - HALT: all outputs 0 except illegal_o=1. HALT is held until reset.
  - An unknown R-type funct also traps, from RTYPEEX -> HALT, with no writeback.
- Undefined:
  - Unknown opcodes return to FETCH as NOP, and unknown funct executes as ADD.
  - illegal_o is tied 0 and the HALT state does not exist.

Decomposition:
- Shared package/defines:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALUCONT_* codes
  - ALUSRCB_* codes
  - PCSRC_* codes
- One sub-module, ctrl_aludec: purely combinational (aluop[1:0], funct) -> alucont. aluop is 00 ADD, 01 SUB, 10 funct-decoded.

Test Plan:
- Reset mid-instruction: hold rst=0 during MEMWB of LW -> regwrite_o=0 that cycle; after release the first cycle is FETCH with memread_o=1, iord_o=0, alusrcb_o=001.
- LW op=100011 with memready_i=1 always -> five cycles FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMWB shows regwrite=1, memtoreg=1, regdst=0. pcen_o high only in cycle 1.
- SW with memready_i low for 3 cycles in MEMWR -> memwrite_o=1, iord_o=1 for 4 consecutive cycles; then FETCH. regwrite_o never 1.
- BEQ op=000100: with zero_i=1 -> BEQEX gives pcen=1, pcsource=01, alucont=110. Repeat with zero_i=0 -> pcen=0.
- R-type funct=101010 -> RTYPEEX alucont=111, RTYPEWB regdst=1. J op=000010 -> JEX pcsource=10, pcen=1.
- op=111111: with the macro -> illegal_o=1, FSM held with all strobes 0 until rst=0. Without the macro -> DECODE to FETCH, with no writes.
